escape_parser: RTL
==================

# escape_parser

Byte-stream front end of the terminal parser. Consumes decoded host bytes from the receive path, recognises printable characters, C0 controls, two-byte ESC sequences and CSI sequences (with up to two numeric parameters and an optional DEC private `?` marker), and emits one registered command pulse per recognised item. Its `commandReady`/`commandType`/`param` outputs drive the mode-control, cursor-control and text-write stages directly.

## Interface
- No parameters. Shared constants come from `DataType.svh`.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `dataValid`  in  1  `data` holds a new byte this cycle; one byte is consumed per asserted cycle.
- `data`  in  8  received byte.
- `commandReady`  out  1  one-cycle pulse: `commandType`/`param` valid.
- `commandType`  out  CommandsType  decoded command; holds its value between pulses.
- `param`  out  Param_t  `Pn1`, `Pn2` (8 b each), `Pchar` (8 b), `Pcount` (2 b); holds its value between pulses.

## Operation
- States:
  - GROUND: printable 0x20–0x7E → INPUT with `Pchar`=byte.
  - GROUND controls: 0x08 → BS, 0x09 → HT, 0x0A/0x0B/0x0C → LF, 0x0D → CR.
  - GROUND other: 0x1B → ESC. Other controls and 0x7F–0xFF are dropped.
  - ESC: `[` → CSI; clear accumulators, `Pcount`=0, private=0.
  - ESC finals: `7` → DECSC, `8` → DECRC, `D` → IND, `M` → RI, `E` → NEL, `c` → RIS. Each emits and returns to GROUND. Any other byte returns to GROUND silently.
  - CSI: `?` as the first byte sets private. Digit: acc = acc*10 + d.
  - CSI `;`: close the current parameter; index++ (saturates at 3). Parameters beyond the second are parsed and discarded.
  - CSI final 0x40–0x7E: close the current parameter, emit, go to GROUND.
- Final mapping:
  - `A` CUU, `B` CUD, `C` CUF, `D` CUB, `H`/`f` CUP, `J` ED, `K` EL, `m` SGR, `r` DECSTBM.
  - `h`/`l`: SM/RM, or DECSET/DECRST when private.
  - Unknown final: silent return to GROUND.
- Abort: 0x18 or 0x1A in any state → GROUND, no emit. 0x1B in ESC/CSI restarts at ESC.
- C0 controls (0x08–0x0D) inside CSI execute immediately as in GROUND, and the CSI state is kept.
- Any other CSI byte (intermediates 0x20–0x2F, `?` not first, `<=>`) → IGNORE state. IGNORE discards bytes until a final byte, then returns to GROUND with no emit.
- Arithmetic:
  - Accumulator is 9 b internally and saturates at 255. Once saturated it stays 255 for the rest of that parameter.
  - An empty parameter is 0; defaulting (0→1) is left to consumers.
  - `Pcount` = number of parameters closed, saturating at 3. `ESC[r` gives `Pcount`=1, `Pn1`=0.
- Unwritten `Pn2` is 0. `Pchar` = final or printable byte.

## Timing
- Registered output. The byte accepted at cycle N produces `commandReady` high during cycle N+1 only.
- A new byte is accepted every cycle; back-to-back commands give consecutive pulses.
- Reset values: state GROUND, `commandReady` 0, `commandType` EMPTY, all `param` fields 0, accumulators 0.
- Reset mid-sequence discards the partial sequence; no pulse is produced.
- No backpressure: downstream must accept one command per cycle.

## Structure
- `DataType.svh`:
  - Extend the `CommandsType` enum with EMPTY, INPUT, BS, HT, LF, CR, DECSC, DECRC, IND, RI, NEL, RIS, CUU, CUD, CUF, CUB, CUP, ED, EL, SGR, SM, RM, DECSET, DECRST. DECSTBM already exists.
  - Extend `Param_t` with `Pchar` and `Pcount`.
- Sub-module `param_accumulator`: decimal digit accumulation with saturation, plus clear/close controls. The parser FSM stays in this block.

## Test plan
- `ESC [ 5 ; 2 0 r` → one pulse 1 cycle after `r`: DECSTBM, `Pn1`=5, `Pn2`=20, `Pcount`=2.
- `A`, `ESC[3A` fed back-to-back → INPUT with `Pchar`=0x41, then CUU with `Pn1`=3; no gap between the parser-ready bytes.
- `ESC[999;1H` → CUP, `Pn1`=255 (saturated), `Pn2`=1.
- `ESC[?25l` → DECRST, `Pn1`=25. Then `ESC[4h` → SM, `Pn1`=4.
- `ESC[1;2;3;4m` → SGR, `Pn1`=1, `Pn2`=2, `Pcount`=3. `ESC[1` then 0x18 then `x` → only INPUT 0x78.
- Assert `rst` after `ESC[12` → no pulse; outputs return to reset values. A following `ESC[r` → DECSTBM, `Pn1`=0, `Pcount`=1.

Source files
------------

// File: rtl/escape_parser_pkg.sv
// Command and parameter types shared by the escape-sequence parser and its consumers,
// plus byte-class and decimal-accumulation helpers.
package escape_parser_pkg;

  typedef enum logic [4:0] {
    EMPTY   = 5'd0,  INPUT   = 5'd1,  BS      = 5'd2,  HT      = 5'd3,
    LF      = 5'd4,  CR      = 5'd5,  DECSC   = 5'd6,  DECRC   = 5'd7,
    IND     = 5'd8,  RI      = 5'd9,  NEL     = 5'd10, RIS     = 5'd11,
    CUU     = 5'd12, CUD     = 5'd13, CUF     = 5'd14, CUB     = 5'd15,
    CUP     = 5'd16, ED      = 5'd17, EL      = 5'd18, SGR     = 5'd19,
    SM      = 5'd20, RM      = 5'd21, DECSET  = 5'd22, DECRST  = 5'd23,
    DECSTBM = 5'd24
  } CommandsType;

  typedef struct packed {
    logic [7:0] Pn1;
    logic [7:0] Pn2;
    logic [7:0] Pchar;
    logic [1:0] Pcount;
  } Param_t;

  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_CAN      = 8'h18;
  localparam logic [7:0] CH_SUB      = 8'h1A;
  localparam logic [7:0] CH_CSI_OPEN = 8'h5B;
  localparam logic [7:0] CH_PRIVATE  = 8'h3F;
  localparam logic [7:0] CH_SEP      = 8'h3B;
  localparam logic [8:0] ACC_MAX     = 9'd255;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_abort(input logic [7:0] b);
    return (b == CH_CAN) || (b == CH_SUB);
  endfunction

  function automatic logic is_c0_exec(input logic [7:0] b);
    return (b >= 8'h08) && (b <= 8'h0D);
  endfunction

  function automatic CommandsType c0_cmd(input logic [7:0] b);
    CommandsType r;
    case (b)
      8'h08:               r = BS;
      8'h09:               r = HT;
      8'h0A, 8'h0B, 8'h0C: r = LF;
      8'h0D:               r = CR;
      default:             r = EMPTY;
    endcase
    return r;
  endfunction

  function automatic CommandsType esc_final_cmd(input logic [7:0] b);
    CommandsType r;
    case (b)
      8'h37:   r = DECSC;
      8'h38:   r = DECRC;
      8'h44:   r = IND;
      8'h4D:   r = RI;
      8'h45:   r = NEL;
      8'h63:   r = RIS;
      default: r = EMPTY;
    endcase
    return r;
  endfunction

  function automatic CommandsType csi_final_cmd(input logic [7:0] b, input logic priv);
    CommandsType r;
    case (b)
      8'h41:        r = CUU;
      8'h42:        r = CUD;
      8'h43:        r = CUF;
      8'h44:        r = CUB;
      8'h48, 8'h66: r = CUP;
      8'h4A:        r = ED;
      8'h4B:        r = EL;
      8'h6D:        r = SGR;
      8'h72:        r = DECSTBM;
      8'h68:        r = priv ? DECSET : SM;
      8'h6C:        r = priv ? DECRST : RM;
      default:      r = EMPTY;
    endcase
    return r;
  endfunction

  // acc*10 + digit, clamped so a saturated parameter stays at 255.
  function automatic logic [8:0] acc_step(input logic [8:0] acc, input logic [3:0] digit);
    logic [12:0] sum;
    sum = ({4'd0, acc} * 13'd10) + {9'd0, digit};
    if (sum > {4'd0, ACC_MAX}) begin
      return ACC_MAX;
    end else begin
      return sum[8:0];
    end
  endfunction

  function automatic Param_t make_param(input logic [7:0] pn1, input logic [7:0] pn2,
                                        input logic [7:0] pchar, input logic [1:0] pcount);
    Param_t p;
    p.Pn1    = pn1;
    p.Pn2    = pn2;
    p.Pchar  = pchar;
    p.Pcount = pcount;
    return p;
  endfunction

endpackage

// File: rtl/escape_parser_param_accumulator.sv
// Decimal CSI parameter accumulation: saturating digit accumulator plus the first two
// closed parameters and a saturating count of closed parameters.
module param_accumulator
  import escape_parser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_digit,
  input  logic [3:0] i_digit_val,
  input  logic       i_close,
  output logic [7:0] o_pn1,
  output logic [7:0] o_pn2,
  output logic [1:0] o_count
);

  logic [8:0] r_acc;
  logic [7:0] r_pn1;
  logic [7:0] r_pn2;
  logic [1:0] r_count;

  // Outputs show the parameter set as if the current parameter were closed now, so a
  // final byte can emit its own trailing parameter in the same cycle.
  always_comb begin
    if (r_count == 2'd0) begin
      o_pn1 = r_acc[7:0];
    end else begin
      o_pn1 = r_pn1;
    end
    if (r_count == 2'd1) begin
      o_pn2 = r_acc[7:0];
    end else begin
      o_pn2 = r_pn2;
    end
    if (r_count == 2'd3) begin
      o_count = 2'd3;
    end else begin
      o_count = r_count + 2'd1;
    end
  end

  // Accumulator and closed-parameter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= 9'd0;
      r_pn1   <= 8'd0;
      r_pn2   <= 8'd0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_acc   <= 9'd0;
      r_pn1   <= 8'd0;
      r_pn2   <= 8'd0;
      r_count <= 2'd0;
    end else if (i_close) begin
      r_acc   <= 9'd0;
      r_pn1   <= o_pn1;
      r_pn2   <= o_pn2;
      r_count <= o_count;
    end else if (i_digit) begin
      r_acc   <= acc_step(r_acc, i_digit_val);
    end else begin
      r_acc   <= r_acc;
    end
  end

endmodule

// File: rtl/escape_parser.sv
// Byte-stream front end of the terminal parser: printable, C0, ESC and CSI recognition
// with one registered command pulse per recognised item.
module escape_parser
  import escape_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        dataValid,
  input  logic [7:0]  data,
  output logic        commandReady,
  output CommandsType commandType,
  output Param_t      param
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_ESC    = 2'd1,
    ST_CSI    = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_private;
  logic        r_first;
  logic        r_command_ready;
  CommandsType r_command_type;
  Param_t      r_param;

  logic        w_acc_clear;
  logic        w_acc_digit;
  logic        w_acc_close;
  logic [7:0]  w_pn1;
  logic [7:0]  w_pn2;
  logic [1:0]  w_count;
  CommandsType w_c0_cmd;
  CommandsType w_esc_cmd;
  CommandsType w_csi_cmd;

  assign w_c0_cmd  = c0_cmd(data);
  assign w_esc_cmd = esc_final_cmd(data);
  assign w_csi_cmd = csi_final_cmd(data, r_private);

  // Any final byte closes the open parameter; unknown finals are dropped anyway.
  assign w_acc_clear = dataValid && (r_state == ST_ESC) && (data == CH_CSI_OPEN);
  assign w_acc_digit = dataValid && (r_state == ST_CSI) && is_digit(data);
  assign w_acc_close = dataValid && (r_state == ST_CSI) && ((data == CH_SEP) || is_final(data));

  param_accumulator u_param_accumulator (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_acc_clear),
    .i_digit     (w_acc_digit),
    .i_digit_val (data[3:0]),
    .i_close     (w_acc_close),
    .o_pn1       (w_pn1),
    .o_pn2       (w_pn2),
    .o_count     (w_count)
  );

  // Parser FSM with registered command outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_GROUND;
      r_private       <= 1'b0;
      r_first         <= 1'b0;
      r_command_ready <= 1'b0;
      r_command_type  <= EMPTY;
      r_param         <= make_param(8'd0, 8'd0, 8'd0, 2'd0);
    end else begin
      r_command_ready <= 1'b0;
      if (dataValid) begin
        case (r_state)
          ST_GROUND: begin
            if (is_printable(data)) begin
              r_command_ready <= 1'b1;
              r_command_type  <= INPUT;
              r_param         <= make_param(8'd0, 8'd0, data, 2'd0);
            end else if (is_c0_exec(data)) begin
              r_command_ready <= 1'b1;
              r_command_type  <= w_c0_cmd;
              r_param         <= make_param(8'd0, 8'd0, data, 2'd0);
            end else if (data == CH_ESC) begin
              r_state <= ST_ESC;
            end else begin
              r_state <= ST_GROUND;
            end
          end
          ST_ESC: begin
            if (data == CH_CSI_OPEN) begin
              r_state   <= ST_CSI;
              r_private <= 1'b0;
              r_first   <= 1'b1;
            end else if (data == CH_ESC) begin
              r_state <= ST_ESC;
            end else begin
              r_state <= ST_GROUND;
              if (w_esc_cmd != EMPTY) begin
                r_command_ready <= 1'b1;
                r_command_type  <= w_esc_cmd;
                r_param         <= make_param(8'd0, 8'd0, data, 2'd0);
              end
            end
          end
          ST_CSI: begin
            if (is_abort(data)) begin
              r_state <= ST_GROUND;
            end else if (data == CH_ESC) begin
              r_state <= ST_ESC;
            end else if (is_c0_exec(data)) begin
              // Embedded C0 controls execute without disturbing the sequence.
              r_command_ready <= 1'b1;
              r_command_type  <= w_c0_cmd;
              r_param         <= make_param(8'd0, 8'd0, data, 2'd0);
            end else if ((data == CH_PRIVATE) && r_first) begin
              r_private <= 1'b1;
              r_first   <= 1'b0;
            end else if (is_digit(data) || (data == CH_SEP)) begin
              r_first <= 1'b0;
            end else if (is_final(data)) begin
              r_state <= ST_GROUND;
              if (w_csi_cmd != EMPTY) begin
                r_command_ready <= 1'b1;
                r_command_type  <= w_csi_cmd;
                r_param         <= make_param(w_pn1, w_pn2, data, w_count);
              end
            end else begin
              r_state <= ST_IGNORE;
            end
          end
          ST_IGNORE: begin
            if (is_final(data) || is_abort(data)) begin
              r_state <= ST_GROUND;
            end else begin
              r_state <= ST_IGNORE;
            end
          end
          default: begin
            r_state <= ST_GROUND;
          end
        endcase
      end
    end
  end

  assign commandReady = r_command_ready;
  assign commandType  = r_command_type;
  assign param        = r_param;

endmodule
